// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad entry / two-digit display scheduler.
package keypad_pkg;

  typedef enum logic [1:0] {
    SHOW_R   = 2'd0,
    BLANK_RL = 2'd1,
    SHOW_L   = 2'd2,
    BLANK_LR = 2'd3
  } sched_state_t;

  localparam logic [1:0] ANODE_OFF = 2'b11;

  // Indexed by {row_idx, col_idx}; entry 0 is r0c0.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Row/column one-hot key code to hex digit; valid only for a single clean key.
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [7:0] rc,
  output logic [3:0] hex,
  output logic       valid
);

  assign valid = is_onehot4(rc[7:4]) && is_onehot4(rc[3:0]);
  assign hex   = KEY_MAP[{onehot_idx(rc[7:4]), onehot_idx(rc[3:0])}];

endmodule

// File: rtl/keypad_display_sched.sv
// Two-digit key history plus a time-multiplexed display scheduler with
// blanking dead-time between digits.
module keypad_display_sched
  import keypad_pkg::*;
#(
  parameter int REFRESH_COUNT = 24000,
  parameter int BLANK_COUNT   = 480,
  parameter int CNT_W         = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_rc,
  output logic [3:0] seg_digit,
  output logic [1:0] anode,
  output logic       new_key,
  output logic       key_err
);

  sched_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] left_dig_q, left_dig_d, right_dig_q, right_dig_d;
  logic left_v_q, left_v_d, right_v_q, right_v_d;
  logic [3:0] seg_q, seg_d;
  logic [1:0] anode_q, anode_d;
  logic new_key_q, key_err_q;
  logic [3:0] dec_hex;
  logic dec_valid, last;

  keypad_decode u_dec (
    .rc   (key_rc),
    .hex  (dec_hex),
    .valid(dec_valid)
  );

  always_comb begin
    if (state_q == SHOW_R || state_q == SHOW_L)
      last = (cnt_q == CNT_W'(REFRESH_COUNT - 1));
    else
      last = (cnt_q == CNT_W'(BLANK_COUNT - 1));
    cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
    state_d = state_q;
    if (last) begin
      case (state_q)
        SHOW_R:   state_d = BLANK_RL;
        BLANK_RL: state_d = SHOW_L;
        SHOW_L:   state_d = BLANK_LR;
        default:  state_d = SHOW_R;
      endcase
    end

    left_dig_d  = left_dig_q;
    left_v_d    = left_v_q;
    right_dig_d = right_dig_q;
    right_v_d   = right_v_q;
    if (key_valid && dec_valid) begin
      left_dig_d  = right_dig_q;
      left_v_d    = right_v_q;
      right_dig_d = dec_hex;
      right_v_d   = 1'b1;
    end

    // Outputs are built from next state and next history so digit value and
    // anode move together on one edge and a new key shows up immediately.
    seg_d   = seg_q;
    anode_d = ANODE_OFF;
    case (state_d)
      SHOW_R: begin
        seg_d   = right_dig_d;
        anode_d = right_v_d ? 2'b10 : ANODE_OFF;
      end
      SHOW_L: begin
        seg_d   = left_dig_d;
        anode_d = left_v_d ? 2'b01 : ANODE_OFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SHOW_R;
      cnt_q       <= '0;
      left_dig_q  <= 4'd0;
      right_dig_q <= 4'd0;
      left_v_q    <= 1'b0;
      right_v_q   <= 1'b0;
      seg_q       <= 4'd0;
      anode_q     <= ANODE_OFF;
      new_key_q   <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      left_dig_q  <= left_dig_d;
      right_dig_q <= right_dig_d;
      left_v_q    <= left_v_d;
      right_v_q   <= right_v_d;
      seg_q       <= seg_d;
      anode_q     <= anode_d;
      new_key_q   <= key_valid && dec_valid;
      key_err_q   <= key_valid && !dec_valid;
    end
  end

  assign seg_digit = seg_q;
  assign anode     = anode_q;
  assign new_key   = new_key_q;
  assign key_err   = key_err_q;

endmodule

// File: tb/tb_keypad_display_sched.sv
// Scoreboard bench: key events queue expected results, a negedge monitor pops
// them on new_key/key_err and checks the displayed digits against a history model.
module tb_keypad_display_sched;

  localparam int R = 20;
  localparam int B = 4;
  localparam int FRAME = 2 * R + 2 * B;

  typedef struct packed {
    logic       err;
    logic [3:0] hx;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_rc = 8'd0;
  logic [3:0] seg_digit;
  logic [1:0] anode;
  logic       new_key, key_err;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  logic rst_q = 1'b1;
  logic [3:0] m_left = 4'd0, m_right = 4'd0;
  logic m_lv = 1'b0, m_rv = 1'b0;

  keypad_display_sched #(.REFRESH_COUNT(R), .BLANK_COUNT(B), .CNT_W(15)) dut (
    .clk      (clk),
    .reset    (reset),
    .key_valid(key_valid),
    .key_rc   (key_rc),
    .seg_digit(seg_digit),
    .anode    (anode),
    .new_key  (new_key),
    .key_err  (key_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic ok, input int act, input int req);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) rst_q <= reset;

  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      chk("reset_outputs", anode == 2'b11 && seg_digit == 4'd0 && !new_key && !key_err,
          {anode, seg_digit, new_key, key_err}, 8'b1100_0000);
      m_left = 4'd0; m_right = 4'd0; m_lv = 1'b0; m_rv = 1'b0;
      exp_q.delete();
    end else begin
      if (new_key || key_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 1'b0, {new_key, key_err}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", new_key == !e.err && key_err == e.err,
              {new_key, key_err}, {!e.err, e.err});
          if (!e.err) begin
            m_left = m_right; m_lv = m_rv;
            m_right = e.hx;   m_rv = 1'b1;
          end
        end
      end
      chk("anode_not_both", anode != 2'b00, anode, 2'b11);
      if (anode == 2'b10) chk("right_digit", m_rv && seg_digit == m_right, seg_digit, m_right);
      if (anode == 2'b01) chk("left_digit", m_lv && seg_digit == m_left, seg_digit, m_left);
    end
  end

  task automatic press(input logic [7:0] rc, input logic err, input logic [3:0] hx);
    exp_t e;
    @(posedge clk); #1;
    key_valid = 1'b1; key_rc = rc;
    e.err = err; e.hx = hx; exp_q.push_back(e);
    @(posedge clk); #1;
    key_valid = 1'b0; key_rc = 8'd0;
  endtask

  // Returns at the negedge where anode first becomes val.
  task automatic wait_anode(input logic [1:0] val, input string name);
    logic [1:0] prev;
    bit found;
    found = 0;
    @(negedge clk);
    prev = anode;
    for (int k = 0; k < 4 * FRAME && !found; k++) begin
      @(negedge clk);
      if (anode == val && prev != val) found = 1;
      prev = anode;
    end
    if (!found) chk(name, 1'b0, anode, val);
  endtask

  task automatic run_len(input logic [1:0] val, output int n);
    n = 0;
    for (int k = 0; k < 4 * FRAME && anode == val; k++) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle for two frames: nothing may light.
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      chk("idle_anode", anode == 2'b11, anode, 2'b11);
    end

    press(8'b0001_0010, 1'b0, 4'h2);
    wait_anode(2'b10, "first_key_shown");
    chk("first_key_seg", seg_digit == 4'h2, seg_digit, 4'h2);
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      chk("left_blank", anode != 2'b01, anode, 2'b11);
    end

    press(8'b1000_0010, 1'b0, 4'h0);
    press(8'b0100_1000, 1'b0, 4'hC);
    wait_anode(2'b10, "dwell_start");
    run_len(2'b10, n); chk("dwell_show_r", n == R, n, R);
    run_len(2'b11, n); chk("dwell_blank_rl", n == B, n, B);
    chk("left_seg_0", anode == 2'b01 && seg_digit == 4'h0, seg_digit, 4'h0);
    run_len(2'b01, n); chk("dwell_show_l", n == R, n, R);
    run_len(2'b11, n); chk("dwell_blank_lr", n == B, n, B);
    chk("right_seg_c", anode == 2'b10 && seg_digit == 4'hC, seg_digit, 4'hC);

    press(8'b0001_0011, 1'b1, 4'h0);
    wait_anode(2'b10, "err_right");
    chk("err_right_kept", seg_digit == 4'hC, seg_digit, 4'hC);
    wait_anode(2'b01, "err_left");
    chk("err_left_kept", seg_digit == 4'h0, seg_digit, 4'h0);

    @(posedge clk); #1;
    key_valid = 1'b1; key_rc = 8'b0010_0001; exp_q.push_back(5'b0_0100);
    @(posedge clk); #1;
    key_rc = 8'b0001_1000; exp_q.push_back(5'b0_1010);
    @(posedge clk); #1;
    key_valid = 1'b0; key_rc = 8'd0;
    wait_anode(2'b01, "b2b_left");
    chk("b2b_left_4", seg_digit == 4'h4, seg_digit, 4'h4);
    wait_anode(2'b10, "b2b_right");
    chk("b2b_right_a", seg_digit == 4'hA, seg_digit, 4'hA);

    // Reset in the middle of SHOW_L, then a key right away must show on the right.
    wait_anode(2'b01, "pre_reset_left");
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    press(8'b1000_0100, 1'b0, 4'hF);
    @(negedge clk);
    chk("post_reset_show_r", anode == 2'b10 && seg_digit == 4'hF, {anode, seg_digit}, {2'b10, 4'hF});
    repeat (2 * FRAME) @(negedge clk);

    chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_display_sched.md
Name: keypad_display_sched

Overview:
- Consumes debounced key events from the keypad scanner and keeps a two-digit entry history: the most recent key is the right digit, the previous key is the left digit.
- Time-multiplexes the single shared seven-segment decoder between the two display digits.
- Inserts a blanking dead-time at every digit switch to prevent ghosting.
- Sits between the keypad scanner and the seven-segment decoder/anode drivers in the top level.

Parameters:
- REFRESH_COUNT, 24000: clk cycles each digit is shown (48 MHz / 24000 = 2 kHz per digit, 1 kHz frame).
- BLANK_COUNT, 480: clk cycles both anodes are off between digits (10 us at 48 MHz); must be ≥1 and < REFRESH_COUNT.
- CNT_W, 15: width of the shared phase counter; must hold max(REFRESH_COUNT, BLANK_COUNT)-1.

Ports:
- clk, input, 1: system clock (48 MHz).
- reset, input, 1: synchronous, active-high reset.
- key_valid, input, 1: single-cycle pulse, one per accepted key press.
- key_rc, input, 8: {row one-hot[3:0], col one-hot[3:0]}, sampled only when key_valid=1.
- seg_digit, output, 4: hex value presented to the shared seven-segment decoder.
- anode, output, 2: digit enables, active-low; [0]=right, [1]=left.
- new_key, output, 1: registered pulse, one cycle after a valid key is stored.
- key_err, output, 1: registered pulse, one cycle after a key_valid whose row or col field is not exactly one-hot.

Behaviour:
- Decode map (row r, col c, c=0 leftmost):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- History registers: left_d, right_d (4 b each) and valid flags left_v, right_v.
  - On a valid key_valid: left_d<=right_d, left_v<=right_v, right_d<=decoded value, right_v<=1. Update is visible on the next cycle.
  - Invalid code: history unchanged; key_err=1 for one cycle.
- Scheduler FSM states: SHOW_R, BLANK_RL, SHOW_L, BLANK_LR, cycling in that order.
  - Phase counter counts 0..N-1, then clears and advances the state.
  - N = REFRESH_COUNT in SHOW states, BLANK_COUNT in BLANK states.
- Outputs are registered, derived from the current state and history:
  - SHOW_R: anode=2'b10 if right_v, else 2'b11; seg_digit=right_d.
  - SHOW_L: anode=2'b01 if left_v, else 2'b11; seg_digit=left_d.
  - BLANK states: anode=2'b11; seg_digit holds its previous value.
- Seg_digit and anode change on the same edge; no cycle shows a digit with the wrong value.
- A key arriving mid-SHOW is reflected on the following cycle's seg_digit; no frame restart, phase counter undisturbed.
- key_valid in any state (including BLANK) is accepted; back-to-back key_valid on consecutive cycles are both stored in order.
- Reset values:
  - Scheduler: state=SHOW_R, counter=0.
  - History: left_d=right_d=0, left_v=right_v=0.
  - Outputs: anode=2'b11, seg_digit=0, new_key=0, key_err=0.
- Reset mid-frame forces the reset values on the next edge; history is lost.
- Both anodes are never low simultaneously in any cycle, including across reset.

Decomposition:
- Shared package keypad_pkg:
  - sched_state_t enum (SHOW_R, BLANK_RL, SHOW_L, BLANK_LR).
  - ANODE_OFF = 2'b11 constant.
  - 4x4 key map constant used by the decoder.
- Sub-module keypad_decode (combinational):
  - Inputs: rc[7:0].
  - Outputs: hex[3:0] and valid, where valid=1 only when row and col are both one-hot.
- Top of this block: history registers, scheduler FSM, counter, output registers.

Test Plan:
- Reset, then no keys, run 2 frames -> anode stays 2'b11 throughout; new_key never asserts.
- key_valid with key_rc=8'b0001_0010 (r0,c1) -> right_d=2, new_key pulse; in SHOW_R anode=2'b10, seg_digit=4'h2; left stays blank.
- Keys r3c1 then r2c3 -> seg_digit=4'h0 while anode=2'b01 and 4'hC while anode=2'b10.
  - Measure: SHOW dwell = 24000 cycles, BLANK = 480 cycles with anode=2'b11.
- key_rc=8'b0001_0011 (two cols) -> key_err pulse; history and display unchanged.
- Back-to-back key_valid on two consecutive cycles (r1c0, then r0c3) -> left=4, right=A, two new_key pulses.
- Assert reset during SHOW_L with both digits valid -> next cycle anode=2'b11, state SHOW_R, digits cleared.
- Scoreboard on every cycle -> anode!=2'b00.
